instr_decode_stage: RTL and testbench
=====================================

Name: instr_decode_stage

Overview:
Pipelined instruction-decode stage directly upstream of the ALU. Accepts 32-bit MIPS-style instruction words from fetch over a valid/ready handshake. Produces the ALU's 12-bit control code, extended immediate, register addresses and writeback/memory controls. Output is registered behind a 2-entry skid buffer, so fetch and the register-read/ALU side can stall independently without losing throughput.

Parameters:
DATA_W, 32, instruction and immediate width
CNT_W, 12, ALU control code width
RA_W, 5, register address width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush
in_valid  in  1  instr valid from fetch
in_ready  out  1  stage can accept instr
instr  in  DATA_W  instruction word
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts bundle
cnt  out  CNT_W  ALU control code
rs_addr  out  RA_W  instr[25:21]
rt_addr  out  RA_W  instr[20:16]
dest_addr  out  RA_W  writeback register
imm  out  DATA_W  extended immediate
wr_en  out  1  register writeback required
mem_rd  out  1  load
mem_wr  out  1  store
illegal  out  1  unsupported encoding

Behaviour:
- Reset (async, rst_n low): out_valid=0, both buffer entries invalid, all bundle outputs 0, in_ready=1. Inputs are ignored while rst_n is low.
- Decode (combinational, before the register): op=instr[31:26], fn=instr[5:0].
- op=0, fn in {32 add, 34 sub, 24 mult, 26 div, 36 and, 37 or}: cnt={6'b0,fn}, dest=rd (instr[15:11]), wr_en=1, imm=0.
- op in {8 addi, 12 andi, 13 ori, 32 lb, 40 sb}: cnt={op,6'b0}, giving 512/768/832/2048/2560. dest=rt.
- Immediate extension: sign-extended for 8/32/40; zero-extended for 12/13.
- Per-opcode controls: wr_en=1 except sb. mem_rd=1 only for lb. mem_wr=1 only for sb.
- Any other op/fn: cnt=0, wr_en=mem_rd=mem_wr=0, illegal=1. The bundle still flows so the ALU yields 0.
- Handshake: a transfer happens when valid&ready are both high at a clock edge. Once asserted, out_valid and the bundle hold stable until out_ready.
- Latency: 1 cycle from input acceptance to out_valid when the output register is empty or draining. Throughput is 1 instr/cycle.
- Skid buffer: in_ready is registered and equals !skid_valid.
  - Accept with output occupied and out_ready=0: the word goes to the skid entry, and in_ready drops next cycle.
  - When the output drains: the skid entry moves to the output and in_ready returns next cycle.
  - Order is always preserved.
- Simultaneous accept and drain: the output register takes the skid entry if valid, else the new word. The new word goes to skid only if skid was valid.
- Flush: clears out_valid and skid_valid next cycle. It has priority over a same-cycle accept, and that accepted word is discarded. Bundle data is don't-care after flush; in_ready=1 next cycle.
- Reset mid-stall: all contents are lost immediately. No partial bundle is emitted.

Optional Feature:
DECODE_PERF_CNT_EN
- Defined: adds outputs dec_count[15:0] and illegal_count[15:0]. Both are saturating at 16'hFFFF and count bundles transferred out (out_valid&out_ready), with illegal_count counting only those with illegal=1.
  - Async reset to 0.
  - Flush does not clear them.
  - Counters hold at 16'hFFFF.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package risc_decode_pkg:
  - opcode/funct localparams (OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_LB, OP_SB, FN_ADD, FN_SUB, FN_MULT, FN_DIV, FN_AND, FN_OR)
  - ALU cnt constants (CNT_ADD=32 … CNT_SB=2560)
  - packed struct decode_bundle_t
- Sub-module instr_decoder: purely combinational instr -> decode_bundle_t. The stage wraps it with the skid buffer.

Test Plan:
- add $3,$1,$2 (0x00221820), out_ready=1 -> next cycle out_valid=1, cnt=32, rs=1, rt=2, dest=3, wr_en=1, illegal=0.
- addi $5,$4,-1 (0x2085FFFF) then ori $6,$0,0x8000 (0x34068000) back-to-back -> cnt=512 with imm=0xFFFFFFFF and dest=5, then cnt=832 with imm=0x00008000 and dest=6, on consecutive cycles.
- sb (op 40, imm 0xFFF0) -> cnt=2560, imm=0xFFFFFFF0, wr_en=0, mem_wr=1. lb (op 32) -> cnt=2048, mem_rd=1, wr_en=1.
- Stream of 4 instrs with out_ready held low 3 cycles -> in_ready falls after 2 accepts. The first bundle is held stable. After release, all 4 emerge in order with no loss or duplication.
- j (0x08000010) and op0/fn 0x03 -> cnt=0, illegal=1, wr_en=0. With DECODE_PERF_CNT_EN, illegal_count increments by 2.
- flush asserted with both entries full, plus a same-cycle accept -> out_valid=0 and in_ready=1 next cycle, no stale bundle emitted. rst_n pulse mid-stall -> outputs 0 immediately.

Source files
------------

// File: rtl/risc_decode_pkg.sv
// Shared opcode/funct encodings, ALU control codes and the decoded bundle layout
// used by the instruction decode stage.
package risc_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LB    = 6'd32;
  localparam logic [5:0] OP_SB    = 6'd40;

  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_MULT = 6'd24;
  localparam logic [5:0] FN_DIV  = 6'd26;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;

  // R-type codes are {6'b0,fn}; I-type codes are {op,6'b0}
  localparam logic [11:0] CNT_ADD  = 12'd32;
  localparam logic [11:0] CNT_SUB  = 12'd34;
  localparam logic [11:0] CNT_MULT = 12'd24;
  localparam logic [11:0] CNT_DIV  = 12'd26;
  localparam logic [11:0] CNT_AND  = 12'd36;
  localparam logic [11:0] CNT_OR   = 12'd37;
  localparam logic [11:0] CNT_ADDI = 12'd512;
  localparam logic [11:0] CNT_ANDI = 12'd768;
  localparam logic [11:0] CNT_ORI  = 12'd832;
  localparam logic [11:0] CNT_LB   = 12'd2048;
  localparam logic [11:0] CNT_SB   = 12'd2560;

  typedef struct packed {
    logic [11:0] cnt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic        wr_en;
    logic        mem_rd;
    logic        mem_wr;
    logic        illegal;
  } decode_bundle_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: 32-bit instruction word -> decode_bundle_t.
module instr_decoder
  import risc_decode_pkg::*;
(
  input  logic [31:0]    instr,
  output decode_bundle_t bundle
);

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign op       = instr[31:26];
  assign fn       = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext = {16'h0000, instr[15:0]};

  always_comb begin
    bundle    = '0;
    bundle.rs = instr[25:21];
    bundle.rt = instr[20:16];
    case (op)
      OP_RTYPE: begin
        bundle.dest  = instr[15:11];
        bundle.wr_en = 1'b1;
        case (fn)
          FN_ADD:  bundle.cnt = CNT_ADD;
          FN_SUB:  bundle.cnt = CNT_SUB;
          FN_MULT: bundle.cnt = CNT_MULT;
          FN_DIV:  bundle.cnt = CNT_DIV;
          FN_AND:  bundle.cnt = CNT_AND;
          FN_OR:   bundle.cnt = CNT_OR;
          default: begin
            bundle.dest    = '0;
            bundle.wr_en   = 1'b0;
            bundle.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        bundle.cnt = CNT_ADDI; bundle.dest = instr[20:16];
        bundle.imm = imm_sext; bundle.wr_en = 1'b1;
      end
      OP_ANDI: begin
        bundle.cnt = CNT_ANDI; bundle.dest = instr[20:16];
        bundle.imm = imm_zext; bundle.wr_en = 1'b1;
      end
      OP_ORI: begin
        bundle.cnt = CNT_ORI; bundle.dest = instr[20:16];
        bundle.imm = imm_zext; bundle.wr_en = 1'b1;
      end
      OP_LB: begin
        bundle.cnt = CNT_LB; bundle.dest = instr[20:16];
        bundle.imm = imm_sext; bundle.wr_en = 1'b1; bundle.mem_rd = 1'b1;
      end
      OP_SB: begin
        bundle.cnt = CNT_SB; bundle.dest = instr[20:16];
        bundle.imm = imm_sext; bundle.mem_wr = 1'b1;
      end
      default: bundle.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: instr_decoder behind an output register plus one skid entry; in_ready = !skid_valid.
// Optional DECODE_PERF_CNT_EN adds saturating dec_count/illegal_count outputs.
module instr_decode_stage
  import risc_decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 12,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  cnt,
  output logic [RA_W-1:0]   rs_addr,
  output logic [RA_W-1:0]   rt_addr,
  output logic [RA_W-1:0]   dest_addr,
  output logic [DATA_W-1:0] imm,
  output logic              wr_en,
  output logic              mem_rd,
  output logic              mem_wr,
`ifdef DECODE_PERF_CNT_EN
  output logic [15:0]       dec_count,
  output logic [15:0]       illegal_count,
`endif
  output logic              illegal
);

  decode_bundle_t dec, out_b, skid_b;
  logic           skid_valid;
  logic           accept;

  instr_decoder u_decoder (
    .instr  (instr),
    .bundle (dec)
  );

  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_b      <= '0;
      skid_b     <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      // Output slot frees up; the skid entry is older than any new word.
      if (skid_valid) begin
        out_b      <= skid_b;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_b     <= dec;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_b     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign cnt       = out_b.cnt;
  assign rs_addr   = out_b.rs;
  assign rt_addr   = out_b.rt;
  assign dest_addr = out_b.dest;
  assign imm       = out_b.imm;
  assign wr_en     = out_b.wr_en;
  assign mem_rd    = out_b.mem_rd;
  assign mem_wr    = out_b.mem_wr;
  assign illegal   = out_b.illegal;

`ifdef DECODE_PERF_CNT_EN
  logic drain;
  assign drain = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_count     <= '0;
      illegal_count <= '0;
    end else if (drain) begin
      if (dec_count != 16'hFFFF) dec_count <= dec_count + 16'd1;
      if (out_b.illegal && illegal_count != 16'hFFFF) illegal_count <= illegal_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: driver pushes hand-computed bundles into a queue,
// a negedge monitor compares every presented bundle (and its stability while stalled).
module tb_instr_decode_stage;
  import risc_decode_pkg::*;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, imm;
  logic [11:0] cnt;
  logic [4:0]  rs_addr, rt_addr, dest_addr;
  logic        wr_en, mem_rd, mem_wr, illegal;
`ifdef DECODE_PERF_CNT_EN
  logic [15:0] dec_count, illegal_count;
`endif

  int checks = 0;
  int errors = 0;
  decode_bundle_t q[$];

  instr_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .cnt(cnt), .rs_addr(rs_addr), .rt_addr(rt_addr), .dest_addr(dest_addr),
    .imm(imm), .wr_en(wr_en), .mem_rd(mem_rd), .mem_wr(mem_wr),
`ifdef DECODE_PERF_CNT_EN
    .dec_count(dec_count), .illegal_count(illegal_count),
`endif
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  function automatic decode_bundle_t mk(input logic [11:0] c, input logic [4:0] rs, rt, d,
                                        input logic [31:0] im, input logic w, mr, mw, il);
    decode_bundle_t b;
    b.cnt = c; b.rs = rs; b.rt = rt; b.dest = d; b.imm = im;
    b.wr_en = w; b.mem_rd = mr; b.mem_wr = mw; b.illegal = il;
    return b;
  endfunction

  // Monitor: every presented bundle must match the queue head; pop on transfer.
  always @(negedge clk) begin
    decode_bundle_t got;
    if (rst_n && out_valid) begin
      got = mk(cnt, rs_addr, rt_addr, dest_addr, imm, wr_en, mem_rd, mem_wr, illegal);
      if (q.size() == 0) begin
        chk("spurious_out", 64'(got), 64'h0);
      end else begin
        chk("bundle", 64'(got), 64'(q[0]));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] w, input decode_bundle_t e);
    int t;
    t = 0;
    instr = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    else q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  localparam logic [31:0] I_ADD  = 32'h00221820, I_ADDI = 32'h2085FFFF, I_ORI = 32'h34068000;
  localparam logic [31:0] I_SB   = 32'hA022FFF0, I_LB   = 32'h80640008, I_ANDI = 32'h3087FFFF;
  localparam logic [31:0] I_J    = 32'h08000010, I_BAD  = 32'h00221803;
  localparam logic [31:0] I_SUB  = 32'h00221822, I_MULT = 32'h00221818, I_AND = 32'h00221824;
  localparam logic [31:0] I_OR   = 32'h00221825, I_DIV  = 32'h0022181A;

  decode_bundle_t e_add, e_addi, e_ori, e_sb, e_lb, e_andi, e_j, e_bad;
  decode_bundle_t e_sub, e_mult, e_and, e_or, e_div;

  initial begin
    e_add  = mk(12'd32,   5'd1, 5'd2, 5'd3, 32'h0,        1, 0, 0, 0);
    e_addi = mk(12'd512,  5'd4, 5'd5, 5'd5, 32'hFFFFFFFF, 1, 0, 0, 0);
    e_ori  = mk(12'd832,  5'd0, 5'd6, 5'd6, 32'h00008000, 1, 0, 0, 0);
    e_sb   = mk(12'd2560, 5'd1, 5'd2, 5'd2, 32'hFFFFFFF0, 0, 0, 1, 0);
    e_lb   = mk(12'd2048, 5'd3, 5'd4, 5'd4, 32'h00000008, 1, 1, 0, 0);
    e_andi = mk(12'd768,  5'd4, 5'd7, 5'd7, 32'h0000FFFF, 1, 0, 0, 0);
    e_j    = mk(12'd0,    5'd0, 5'd0, 5'd0, 32'h0,        0, 0, 0, 1);
    e_bad  = mk(12'd0,    5'd1, 5'd2, 5'd0, 32'h0,        0, 0, 0, 1);
    e_sub  = mk(12'd34,   5'd1, 5'd2, 5'd3, 32'h0,        1, 0, 0, 0);
    e_mult = mk(12'd24,   5'd1, 5'd2, 5'd3, 32'h0,        1, 0, 0, 0);
    e_and  = mk(12'd36,   5'd1, 5'd2, 5'd3, 32'h0,        1, 0, 0, 0);
    e_or   = mk(12'd37,   5'd1, 5'd2, 5'd3, 32'h0,        1, 0, 0, 0);
    e_div  = mk(12'd26,   5'd1, 5'd2, 5'd3, 32'h0,        1, 0, 0, 0);

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; instr = 32'h0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_bundle", 64'({cnt, rs_addr, rt_addr, dest_addr, imm, wr_en, mem_rd, mem_wr, illegal}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    send(I_ADD, e_add);
    chk("add_latency", 64'(out_valid), 64'd1);
    send(I_ADDI, e_addi);
    chk("addi_cycle", 64'({out_valid, cnt}), 64'({1'b1, 12'd512}));
    send(I_ORI, e_ori);
    chk("ori_next_cycle", 64'({out_valid, cnt}), 64'({1'b1, 12'd832}));
    send(I_SB, e_sb);
    send(I_LB, e_lb);
    send(I_ANDI, e_andi);
    send(I_J, e_j);
    send(I_BAD, e_bad);
    repeat (3) @(posedge clk); #1;
    chk("idle_drained", 64'(out_valid), 64'd0);

    // Stall: out_ready low for 3 cycles while 4 words stream in.
    out_ready = 1'b0;
    fork
      begin
        send(I_SUB, e_sub); send(I_MULT, e_mult); send(I_AND, e_and); send(I_OR, e_or);
      end
      begin
        repeat (3) @(posedge clk); #1; out_ready = 1'b1;
      end
      begin
        repeat (2) @(posedge clk); @(negedge clk);
        chk("in_ready_drop", 64'(in_ready), 64'd0);
      end
    join
    repeat (3) @(posedge clk); #1;
    chk("stream_complete", 64'(q.size()), 64'd0);

`ifdef DECODE_PERF_CNT_EN
    chk("dec_count", 64'(dec_count), 64'd12);
    chk("illegal_count", 64'(illegal_count), 64'd2);
`endif

    // Flush with output occupied and a same-cycle accept: both discarded.
    out_ready = 1'b0;
    send(I_DIV, e_div);
    instr = I_OR; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; q.delete();
    chk("flush1_out_valid", 64'(out_valid), 64'd0);
    chk("flush1_in_ready", 64'(in_ready), 64'd1);

    // Flush with both entries full.
    send(I_ADD, e_add);
    send(I_ADDI, e_addi);
    chk("both_full_in_ready", 64'(in_ready), 64'd0);
    instr = I_ORI; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; q.delete();
    chk("flush2_out_valid", 64'(out_valid), 64'd0);
    chk("flush2_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("no_stale_after_flush", 64'(out_valid), 64'd0);

    // Reset pulse mid-stall.
    out_ready = 1'b0;
    send(I_LB, e_lb);
    send(I_SB, e_sb);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_bundle", 64'({cnt, imm, wr_en, mem_rd, mem_wr}), 64'd0);
    q.delete();
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("no_partial_after_rst", 64'(out_valid), 64'd0);
`ifdef DECODE_PERF_CNT_EN
    chk("perf_rst", 64'({dec_count, illegal_count}), 64'd0);
`endif

    send(I_ANDI, e_andi);
    chk("post_rst_latency", 64'(out_valid), 64'd1);
    repeat (2) @(posedge clk); #1;
    chk("final_queue_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
